// File: rtl/itch_pkg.sv
// Shared types and constants for the ITCH 5.0 message parser: FSM states,
// supported message type codes and lengths, and the decoded record layout.
package itch_pkg;

  typedef enum logic [2:0] {
    LEN_HI   = 3'd0,
    LEN_LO   = 3'd1,
    BODY     = 3'd2,
    WAIT_CRC = 3'd3,
    OUT_HOLD = 3'd4
  } state_t;

  localparam logic [7:0]  ITCH_ADD     = 8'h41;
  localparam logic [7:0]  ITCH_DEL     = 8'h44;
  localparam logic [7:0]  ITCH_CXL     = 8'h58;
  localparam logic [15:0] ITCH_LEN_ADD = 16'd36;
  localparam logic [15:0] ITCH_LEN_DEL = 16'd19;
  localparam logic [15:0] ITCH_LEN_CXL = 16'd23;

  typedef struct packed {
    logic [7:0]  msg_type;
    logic [15:0] stock_locate;
    logic [15:0] tracking;
    logic [47:0] timestamp;
    logic [63:0] order_ref;
    logic        side;
    logic [31:0] shares;
    logic [63:0] stock;
    logic [31:0] price;
  } itch_msg_t;

  localparam itch_msg_t ITCH_MSG_CLR = {$bits(itch_msg_t){1'b0}};

  function automatic logic type_known(input logic [7:0] t);
    return (t == ITCH_ADD) || (t == ITCH_DEL) || (t == ITCH_CXL);
  endfunction

  function automatic logic [15:0] expected_len(input logic [7:0] t);
    case (t)
      ITCH_ADD: return ITCH_LEN_ADD;
      ITCH_DEL: return ITCH_LEN_DEL;
      ITCH_CXL: return ITCH_LEN_CXL;
      default:  return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/itch_msg_parser_if.sv
// Upstream byte stream from the Ethernet receiver into the ITCH parser,
// including the per-frame CRC verdict.
interface itch_msg_parser_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic       crc_valid;
  logic       crc_ok;

  modport master (output in_byte, in_valid, crc_valid, crc_ok, input in_ready);
  modport slave  (input in_byte, in_valid, crc_valid, crc_ok, output in_ready);
endinterface

// File: rtl/itch_stats.sv
// Saturating event counters for the ITCH parser; one-cycle strobes in,
// registered counts out.
module itch_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ev_msg_ok,
  input  logic        ev_crc_drop,
  input  logic        ev_malformed,
  input  logic        ev_unsupported,
  output logic [31:0] stat_msg_ok,
  output logic [15:0] stat_crc_drop,
  output logic [15:0] stat_malformed,
  output logic [15:0] stat_unsupported
);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counter registers, each advancing by one per strobe and sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_msg_ok      <= 32'd0;
      stat_crc_drop    <= 16'd0;
      stat_malformed   <= 16'd0;
      stat_unsupported <= 16'd0;
    end else begin
      if (ev_msg_ok)      stat_msg_ok      <= sat_inc32(stat_msg_ok);
      if (ev_crc_drop)    stat_crc_drop    <= sat_inc16(stat_crc_drop);
      if (ev_malformed)   stat_malformed   <= sat_inc16(stat_malformed);
      if (ev_unsupported) stat_unsupported <= sat_inc16(stat_unsupported);
    end
  end

endmodule

// File: rtl/itch_msg_parser.sv
// Decodes one length-prefixed ITCH 5.0 message per frame and releases it only on crc_ok.
// Event counters are built only when ITCH_PARSER_STATS_EN is defined; otherwise they read 0.
module itch_msg_parser
  import itch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  itch_msg_parser_if.slave   in_if,
  output logic               msg_valid,
  input  logic               msg_ready,
  output logic [7:0]         msg_type,
  output logic [15:0]        stock_locate,
  output logic [15:0]        tracking,
  output logic [47:0]        timestamp,
  output logic [63:0]        order_ref,
  output logic               side,
  output logic [31:0]        shares,
  output logic [63:0]        stock,
  output logic [31:0]        price,
  output logic [31:0]        stat_msg_ok,
  output logic [15:0]        stat_crc_drop,
  output logic [15:0]        stat_malformed,
  output logic [15:0]        stat_unsupported
);

  state_t      state_r, state_nx_s;
  logic [15:0] len_r;
  logic [15:0] idx_r;
  logic        mal_r;
  logic        unsup_r;
  itch_msg_t   msg_r;
  logic [15:0] len_full_s;
  logic        last_s;
  logic [7:0]  b_s;

  assign b_s        = in_if.in_byte;
  assign len_full_s = {len_r[15:8], b_s};
  assign last_s     = (idx_r == (len_r - 16'd1));

  assign in_if.in_ready = (state_r == LEN_HI) || (state_r == LEN_LO) || (state_r == BODY);
  assign msg_valid      = (state_r == OUT_HOLD);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= LEN_HI;
    else        state_r <= state_nx_s;
  end

  // Next-state logic; a CRC pulse mid-frame means upstream lost bytes, so resync
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      LEN_HI: begin
        if (in_if.in_valid) state_nx_s = LEN_LO;
        else                state_nx_s = LEN_HI;
      end
      LEN_LO: begin
        if (in_if.crc_valid)     state_nx_s = LEN_HI;
        else if (in_if.in_valid) state_nx_s = (len_full_s == 16'd0) ? WAIT_CRC : BODY;
        else                     state_nx_s = LEN_LO;
      end
      BODY: begin
        if (in_if.crc_valid)               state_nx_s = LEN_HI;
        else if (in_if.in_valid && last_s) state_nx_s = WAIT_CRC;
        else                               state_nx_s = BODY;
      end
      WAIT_CRC: begin
        if (in_if.crc_valid) begin
          if (in_if.crc_ok && !mal_r && !unsup_r) state_nx_s = OUT_HOLD;
          else                                    state_nx_s = LEN_HI;
        end else begin
          state_nx_s = WAIT_CRC;
        end
      end
      OUT_HOLD: begin
        if (msg_ready) state_nx_s = LEN_HI;
        else           state_nx_s = OUT_HOLD;
      end
      default: state_nx_s = LEN_HI;
    endcase
  end

  // Length capture, frame flags and big-endian field assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r   <= 16'd0;
      idx_r   <= 16'd0;
      mal_r   <= 1'b0;
      unsup_r <= 1'b0;
      msg_r   <= ITCH_MSG_CLR;
    end else begin
      case (state_r)
        LEN_HI: begin
          if (in_if.in_valid) begin
            len_r[15:8] <= b_s;
            msg_r       <= ITCH_MSG_CLR;
            mal_r       <= 1'b0;
            unsup_r     <= 1'b0;
          end
        end
        LEN_LO: begin
          if (!in_if.crc_valid && in_if.in_valid) begin
            len_r[7:0] <= b_s;
            idx_r      <= 16'd0;
            if (len_full_s == 16'd0) mal_r <= 1'b1;
          end
        end
        BODY: begin
          if (!in_if.crc_valid && in_if.in_valid) begin
            idx_r <= idx_r + 16'd1;
            if (idx_r == 16'd0) begin
              msg_r.msg_type <= b_s;
              if (!type_known(b_s))                   unsup_r <= 1'b1;
              else if (len_r != expected_len(b_s))    mal_r   <= 1'b1;
            end else if (!unsup_r) begin
              // Offsets past the common header depend on the captured type byte
              if (idx_r <= 16'd2)       msg_r.stock_locate <= {msg_r.stock_locate[7:0], b_s};
              else if (idx_r <= 16'd4)  msg_r.tracking     <= {msg_r.tracking[7:0], b_s};
              else if (idx_r <= 16'd10) msg_r.timestamp    <= {msg_r.timestamp[39:0], b_s};
              else if (idx_r <= 16'd18) msg_r.order_ref    <= {msg_r.order_ref[55:0], b_s};
              else if (msg_r.msg_type == ITCH_ADD) begin
                if (idx_r == 16'd19)      msg_r.side   <= (b_s == 8'h42);
                else if (idx_r <= 16'd23) msg_r.shares <= {msg_r.shares[23:0], b_s};
                else if (idx_r <= 16'd31) msg_r.stock  <= {msg_r.stock[55:0], b_s};
                else if (idx_r <= 16'd35) msg_r.price  <= {msg_r.price[23:0], b_s};
              end else if ((msg_r.msg_type == ITCH_CXL) && (idx_r <= 16'd22)) begin
                msg_r.shares <= {msg_r.shares[23:0], b_s};
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign msg_type     = msg_r.msg_type;
  assign stock_locate = msg_r.stock_locate;
  assign tracking     = msg_r.tracking;
  assign timestamp    = msg_r.timestamp;
  assign order_ref    = msg_r.order_ref;
  assign side         = msg_r.side;
  assign shares       = msg_r.shares;
  assign stock        = msg_r.stock;
  assign price        = msg_r.price;

`ifdef ITCH_PARSER_STATS_EN
  logic wait_evt_s, ev_ok_s, ev_crc_s, ev_mal_s, ev_uns_s;

  // Counter priority on a CRC verdict is crc_drop, then malformed, then unsupported
  assign wait_evt_s = (state_r == WAIT_CRC) && in_if.crc_valid;
  assign ev_ok_s    = (state_r == OUT_HOLD) && msg_ready;
  assign ev_crc_s   = wait_evt_s && !in_if.crc_ok;
  assign ev_mal_s   = (in_if.crc_valid && ((state_r == LEN_LO) || (state_r == BODY))) ||
                      (wait_evt_s && in_if.crc_ok && mal_r);
  assign ev_uns_s   = wait_evt_s && in_if.crc_ok && !mal_r && unsup_r;

  itch_stats u_stats (
    .clk              (clk),
    .rst_n            (rst_n),
    .ev_msg_ok        (ev_ok_s),
    .ev_crc_drop      (ev_crc_s),
    .ev_malformed     (ev_mal_s),
    .ev_unsupported   (ev_uns_s),
    .stat_msg_ok      (stat_msg_ok),
    .stat_crc_drop    (stat_crc_drop),
    .stat_malformed   (stat_malformed),
    .stat_unsupported (stat_unsupported)
  );
`else
  assign stat_msg_ok      = 32'd0;
  assign stat_crc_drop    = 16'd0;
  assign stat_malformed   = 16'd0;
  assign stat_unsupported = 16'd0;
`endif

endmodule

// File: tb/tb_itch_msg_parser.sv
// Directed and randomized frames for itch_msg_parser, checked against field values
// the bench encodes itself and a frame-verdict model built from the length/type rules.
module tb_itch_msg_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        msg_valid, msg_ready, side;
  logic [7:0]  msg_type;
  logic [15:0] stock_locate, tracking;
  logic [47:0] timestamp;
  logic [63:0] order_ref, stock;
  logic [31:0] shares, price, stat_msg_ok;
  logic [15:0] stat_crc_drop, stat_malformed, stat_unsupported;

  itch_msg_parser_if bus ();

  itch_msg_parser dut (
    .clk(clk), .rst_n(rst_n), .in_if(bus),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_type(msg_type),
    .stock_locate(stock_locate), .tracking(tracking), .timestamp(timestamp),
    .order_ref(order_ref), .side(side), .shares(shares), .stock(stock), .price(price),
    .stat_msg_ok(stat_msg_ok), .stat_crc_drop(stat_crc_drop),
    .stat_malformed(stat_malformed), .stat_unsupported(stat_unsupported)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int m_ok, m_crc, m_mal, m_uns;

  logic [7:0]  e_type;
  logic [15:0] e_loc, e_trk;
  logic [47:0] e_ts;
  logic [63:0] e_ref, e_stock;
  logic        e_side;
  logic [31:0] e_shares, e_price;
  logic [7:0]  fq[$];
  logic [7:0]  bq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int st(input int v);
`ifdef ITCH_PARSER_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic bit tb_known(input logic [7:0] t);
    return (t == 8'h41) || (t == 8'h44) || (t == 8'h58);
  endfunction

  function automatic int tb_len(input logic [7:0] t);
    return (t == 8'h41) ? 36 : (t == 8'h44) ? 19 : (t == 8'h58) ? 23 : 0;
  endfunction

  task automatic push_be(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i*8 +: 8]);
  endtask

  // Random field values; fields a type does not carry are expected to read 0
  task automatic rand_fields(input logic [7:0] t);
    e_type   = t;
    e_loc    = 16'($urandom);
    e_trk    = 16'($urandom);
    e_ts     = {16'($urandom), 32'($urandom)};
    e_ref    = {32'($urandom), 32'($urandom)};
    e_side   = (t == 8'h41) ? 1'($urandom) : 1'b0;
    e_shares = (t == 8'h41 || t == 8'h58) ? 32'($urandom) : 32'd0;
    e_stock  = (t == 8'h41) ? {32'($urandom), 32'($urandom)} : 64'd0;
    e_price  = (t == 8'h41) ? 32'($urandom) : 32'd0;
  endtask

  task automatic build_msg(input logic [7:0] t, input int len);
    logic [15:0] l16;
    bq = {};
    bq.push_back(t);
    if (tb_known(t)) begin
      push_be(64'(e_loc), 2); push_be(64'(e_trk), 2);
      push_be(64'(e_ts), 6);  push_be(e_ref, 8);
      if (t == 8'h41) begin
        bq.push_back(e_side ? 8'h42 : 8'h53);
        push_be(64'(e_shares), 4); push_be(e_stock, 8); push_be(64'(e_price), 4);
      end else if (t == 8'h58) begin
        push_be(64'(e_shares), 4);
      end
    end
    while (bq.size() < len) bq.push_back(8'($urandom));
    l16 = 16'(len);
    fq = {};
    fq.push_back(l16[15:8]);
    fq.push_back(l16[7:0]);
    for (int i = 0; i < len; i++) fq.push_back(bq[i]);
  endtask

  task automatic send_bytes(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      chk("in_ready_stream", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_byte  = fq[i];
    end
  endtask

  task automatic crc_pulse(input bit ok);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.crc_valid = 1'b1;
    bus.crc_ok    = ok;
    @(negedge clk);
    bus.crc_valid = 1'b0;
    bus.crc_ok    = 1'b0;
  endtask

  task automatic check_fields(input string p);
    chk({p, "_type"}, msg_type, e_type);
    chk({p, "_locate"}, stock_locate, e_loc);
    chk({p, "_tracking"}, tracking, e_trk);
    chk({p, "_timestamp"}, timestamp, e_ts);
    chk({p, "_order_ref"}, order_ref, e_ref);
    chk({p, "_side"}, side, e_side);
    chk({p, "_shares"}, shares, e_shares);
    chk({p, "_stock"}, stock, e_stock);
    chk({p, "_price"}, price, e_price);
  endtask

  task automatic check_stats();
    chk("stat_msg_ok", stat_msg_ok, st(m_ok));
    chk("stat_crc_drop", stat_crc_drop, st(m_crc));
    chk("stat_malformed", stat_malformed, st(m_mal));
    chk("stat_unsupported", stat_unsupported, st(m_uns));
  endtask

  task automatic clear_expect();
    e_type = 8'd0; e_loc = 16'd0; e_trk = 16'd0; e_ts = 48'd0; e_ref = 64'd0;
    e_side = 1'b0; e_shares = 32'd0; e_stock = 64'd0; e_price = 32'd0;
  endtask

  // Full frame with verdict: crc_drop > malformed (len 0 or wrong length) > unsupported
  task automatic run_frame(input logic [7:0] t, input int len, input bit ok,
                           input bit gaps, input int hold);
    int v;
    build_msg(t, len);
    send_bytes(fq.size(), gaps);
    crc_pulse(ok);
    if (!ok) v = 1;
    else if (len == 0 || (tb_known(t) && len != tb_len(t))) v = 2;
    else if (!tb_known(t)) v = 3;
    else v = 0;
    chk("msg_valid_after_crc", msg_valid, 64'(v == 0));
    if (v == 0) begin
      check_fields("rec");
      chk("in_ready_hold", bus.in_ready, 0);
      for (int c = 0; c < hold; c++) begin
        bus.crc_valid = (c == 20);
        bus.crc_ok    = 1'b0;
        @(negedge clk);
        chk("hold_in_ready", bus.in_ready, 0);
        chk("hold_msg_valid", msg_valid, 1);
      end
      bus.crc_valid = 1'b0;
      if (hold > 0) check_fields("held");
      msg_ready = 1'b1;
      if (hold > 0) bus.crc_valid = 1'b1;
      @(negedge clk);
      msg_ready = 1'b0;
      bus.crc_valid = 1'b0;
      chk("post_hs_msg_valid", msg_valid, 0);
      chk("post_hs_in_ready", bus.in_ready, 1);
      m_ok++;
    end else begin
      chk("drop_in_ready", bus.in_ready, 1);
      if (v == 1) m_crc++;
      else if (v == 2) m_mal++;
      else m_uns++;
    end
    check_stats();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t;
    int len, kind;
    bus.in_byte = 8'd0; bus.in_valid = 1'b0; bus.crc_valid = 1'b0; bus.crc_ok = 1'b0;
    msg_ready = 1'b0;
    m_ok = 0; m_crc = 0; m_mal = 0; m_uns = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_msg_valid", msg_valid, 0);
    clear_expect();
    check_fields("rst");
    check_stats();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Test-plan 'A' frame, held 50 cycles with a stray CRC pulse
    e_type = 8'h41; e_loc = 16'h0001; e_trk = 16'h0002; e_ts = 48'h0000_1234_5678;
    e_ref = 64'h1122334455667788; e_side = 1'b1; e_shares = 32'd100;
    e_stock = 64'h4141504C20202020; e_price = 32'd1500000;
    run_frame(8'h41, 36, 1'b1, 1'b0, 50);

    // Same frame with bad CRC, then a good 'D'
    e_type = 8'h41; e_loc = 16'h0001; e_trk = 16'h0002; e_ts = 48'h0000_1234_5678;
    e_ref = 64'h1122334455667788; e_side = 1'b1; e_shares = 32'd100;
    e_stock = 64'h4141504C20202020; e_price = 32'd1500000;
    run_frame(8'h41, 36, 1'b0, 1'b0, 0);
    rand_fields(8'h44);
    run_frame(8'h44, 19, 1'b1, 1'b0, 0);

    // Wrong length 'D' and unsupported 'E'
    rand_fields(8'h44);
    run_frame(8'h44, 20, 1'b1, 1'b0, 0);
    rand_fields(8'h45);
    run_frame(8'h45, 31, 1'b1, 1'b0, 0);

    // Truncated 'A': CRC after 10 body bytes, then a good 'X'
    rand_fields(8'h41);
    build_msg(8'h41, 36);
    send_bytes(12, 1'b0);
    crc_pulse(1'b1);
    m_mal++;
    chk("trunc_msg_valid", msg_valid, 0);
    chk("trunc_in_ready", bus.in_ready, 1);
    check_stats();
    rand_fields(8'h58);
    run_frame(8'h58, 23, 1'b1, 1'b0, 0);

    // Zero length frame
    rand_fields(8'h41);
    run_frame(8'h41, 0, 1'b1, 1'b0, 0);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 2))
        0: t = 8'h41;
        1: t = 8'h44;
        default: t = 8'h58;
      endcase
      len = tb_len(t);
      if (kind == 6) len = tb_len(t) + ($urandom_range(0, 1) ? 1 : -1) * $urandom_range(1, 3);
      if (kind == 7) begin
        t = 8'($urandom_range(0, 255));
        while (tb_known(t)) t = 8'($urandom_range(0, 255));
        len = $urandom_range(1, 40);
      end
      if (kind == 8) len = 0;
      rand_fields(t);
      run_frame(t, len, 1'($urandom_range(0, 4) != 0), 1'b1, 0);
    end

    // Reset mid-BODY, then a clean frame
    rand_fields(8'h41);
    build_msg(8'h41, 36);
    send_bytes(7, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    m_ok = 0; m_crc = 0; m_mal = 0; m_uns = 0;
    clear_expect();
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_msg_valid", msg_valid, 0);
    check_fields("midrst");
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;
    rand_fields(8'h41);
    run_frame(8'h41, 36, 1'b1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
